// File: rtl/clk_div_monitor_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding and
// the error counter width.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam int ERR_W = 8;

endpackage

// File: rtl/clk_div_monitor_if.sv
// Signal bundle between a divided-clock source side (master) and the
// monitor (slave). clk and reset travel as plain ports, not in here.
interface clk_div_monitor_if
    import clk_mon_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             clk_in;
    logic             clr_err;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [WIDTH-1:0] half_period;
    logic             locked;
    logic             stalled;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       state;

    modport master (
        output clk_in, clr_err,
        input  rise_pulse, fall_pulse, half_period, locked, stalled, err_cnt, state
    );

    modport slave (
        input  clk_in, clr_err,
        output rise_pulse, fall_pulse, half_period, locked, stalled, err_cnt, state
    );
endinterface

// File: rtl/clk_div_monitor_sync_edge_det.sv
// Three-flop synchronizer with rise/fall strobe decode. The strobes come
// from flops only, so they are glitch-free and usable as clock enables.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Shift the asynchronous input through two metastability flops and one history flop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;
endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: synchronizes clk_in, measures every half-period,
// locks after LOCK_CNT consecutive in-tolerance half-periods and counts
// mismatches seen while locked. Stalls drop the monitor back to IDLE.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N        = 6,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    clk_div_monitor_if.slave  bus
);
    localparam logic [WIDTH-1:0] HP_MAX = '1;
    localparam int               GC_W   = $clog2(LOCK_CNT + 1);
    // One bit beyond WIDTH+1 keeps meas == 2**WIDTH positive in the compare.
    localparam int               SW     = WIDTH + 2;

    logic                  w_rise;
    logic                  w_fall;
    logic                  w_edge;
    logic [WIDTH-1:0]      r_hp_cnt;
    logic [WIDTH-1:0]      r_half_period;
    logic [WIDTH:0]        w_meas;
    logic signed [SW-1:0]  w_diff;
    logic signed [SW-1:0]  w_abs;
    logic                  w_good;
    logic                  w_sat;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GC_W-1:0]       r_good_cnt;
    logic [GC_W-1:0]       w_gc_nxt;
    logic [GC_W-1:0]       w_gc_inc;
    logic [ERR_W-1:0]      r_err_cnt;
    logic [ERR_W-1:0]      w_err_nxt;
    logic                  w_err_inc;
    logic                  r_stalled;
    logic                  w_stalled_nxt;
    logic                  w_locked;

    sync_edge_det u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (bus.clk_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_edge   = w_rise | w_fall;
    assign w_sat    = (r_hp_cnt == HP_MAX);
    assign w_meas   = {1'b0, r_hp_cnt} + {{WIDTH{1'b0}}, 1'b1};
    assign w_diff   = $signed({1'b0, w_meas}) - $signed(SW'(N));
    assign w_abs    = (w_diff < 0) ? -w_diff : w_diff;
    assign w_good   = (w_abs <= $signed(SW'(TOL)));
    assign w_gc_inc = r_good_cnt + 1'b1;

    // Count clk cycles since the last edge, holding at the top value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hp_cnt <= '0;
        end else if (w_edge) begin
            r_hp_cnt <= '0;
        end else if (!w_sat) begin
            r_hp_cnt <= r_hp_cnt + 1'b1;
        end
    end

    // Capture the just-finished half-period on every edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_half_period <= '0;
        end else if (w_edge) begin
            r_half_period <= w_meas[WIDTH-1:0];
        end
    end

    // State register plus the counters that move with the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_good_cnt <= '0;
            r_err_cnt  <= '0;
            r_stalled  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_gc_nxt;
            r_err_cnt  <= w_err_nxt;
            r_stalled  <= w_stalled_nxt;
        end
    end

    // Next-state logic: decisions on edge cycles, stall detection otherwise.
    always_comb begin
        w_state_nxt   = r_state;
        w_gc_nxt      = r_good_cnt;
        w_err_inc     = 1'b0;
        w_stalled_nxt = r_stalled;
        if (w_edge) begin
            w_stalled_nxt = 1'b0;
            case (r_state)
                IDLE: begin
                    // First edge only anchors the measurement; it is not judged.
                    w_state_nxt = ACQ;
                    w_gc_nxt    = '0;
                end
                ACQ: begin
                    if (w_good) begin
                        if (w_gc_inc == GC_W'(LOCK_CNT)) begin
                            w_state_nxt = LOCKED;
                            w_gc_nxt    = '0;
                        end else begin
                            w_gc_nxt    = w_gc_inc;
                        end
                    end else begin
                        w_gc_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (!w_good) begin
                        w_state_nxt = FAULT;
                        w_err_inc   = 1'b1;
                    end
                end
                FAULT: begin
                    // The recovering edge already counts as one good half-period.
                    if (w_good) begin
                        if (LOCK_CNT == 1) begin
                            w_state_nxt = LOCKED;
                            w_gc_nxt    = '0;
                        end else begin
                            w_state_nxt = ACQ;
                            w_gc_nxt    = GC_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end else if ((r_state != IDLE) && w_sat) begin
            w_state_nxt   = IDLE;
            w_stalled_nxt = 1'b1;
        end

        // A clear request overrides a same-cycle increment.
        if (bus.clr_err) begin
            w_err_nxt = '0;
        end else if (w_err_inc && (r_err_cnt != '1)) begin
            w_err_nxt = r_err_cnt + 1'b1;
        end else begin
            w_err_nxt = r_err_cnt;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        w_locked = (r_state == LOCKED);
    end

    assign bus.rise_pulse  = w_rise;
    assign bus.fall_pulse  = w_fall;
    assign bus.half_period = r_half_period;
    assign bus.locked      = w_locked;
    assign bus.stalled     = r_stalled;
    assign bus.err_cnt     = r_err_cnt;
    assign bus.state       = r_state;
endmodule
